// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: shares the single vga_adapter write port between several
// sprite drawers. Requesters are granted round-robin; the granted rectangle is
// filled pixel by pixel (row-major, one pixel per cycle) and a one-cycle done
// pulse is returned to the requester when the rectangle is finished.
//
// Ports:
//   clock, reset_n      clock and asynchronous active-low reset
//   req[NUM_REQ]        level draw request per requester
//   rect_x/_y/_w/_h     packed per-requester top-left corner and size
//   rect_colour         packed per-requester fill colour
//   grant[NUM_REQ]      one-hot, requester currently being served
//   done[NUM_REQ]       one-cycle completion pulse to the served requester
//   busy                high whenever the FSM is not idle
//   x, y, colour, plot  vga_adapter write port
module vga_plot_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned SIZE_W   = 5,
    parameter int unsigned SCREEN_W = 160,
    parameter int unsigned SCREEN_H = 120
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [8*NUM_REQ-1:0]        rect_x,
    input  logic [7*NUM_REQ-1:0]        rect_y,
    input  logic [SIZE_W*NUM_REQ-1:0]   rect_w,
    input  logic [SIZE_W*NUM_REQ-1:0]   rect_h,
    input  logic [3*NUM_REQ-1:0]        rect_colour,
    output logic [NUM_REQ-1:0]          grant,
    output logic [NUM_REQ-1:0]          done,
    output logic                        busy,
    output logic [7:0]                  x,
    output logic [6:0]                  y,
    output logic [2:0]                  colour,
    output logic                        plot
);

    localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned SUMX_W  = 9;
    localparam int unsigned SUMY_W  = 8;
    localparam logic [SUMX_W-1:0] SCREEN_W_C = SUMX_W'(SCREEN_W);
    localparam logic [SUMY_W-1:0] SCREEN_H_C = SUMY_W'(SCREEN_H);
    localparam logic [IDX_W:0]    NUM_REQ_C  = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAW,
        S_DONE
    } state_t;

    state_t               state, state_nxt;
    logic [IDX_W-1:0]     ptr, ptr_nxt;
    logic [IDX_W-1:0]     sel, sel_nxt;
    logic [7:0]           x0, x0_nxt;
    logic [6:0]           y0, y0_nxt;
    logic [SIZE_W-1:0]    w, w_nxt;
    logic [SIZE_W-1:0]    h, h_nxt;
    logic [2:0]           col, col_nxt;
    logic [SIZE_W-1:0]    cx, cx_nxt;
    logic [SIZE_W-1:0]    cy, cy_nxt;

    logic [NUM_REQ-1:0]   grant_nxt;
    logic [NUM_REQ-1:0]   done_nxt;
    logic                 busy_nxt;
    logic [7:0]           x_nxt;
    logic [6:0]           y_nxt;
    logic [2:0]           colour_nxt;
    logic                 plot_nxt;

    // Pixel to present on the write port next cycle
    logic                 emit;
    logic [7:0]           pix_x0;
    logic [6:0]           pix_y0;
    logic [2:0]           pix_col;
    logic [SIZE_W-1:0]    pix_cx;
    logic [SIZE_W-1:0]    pix_cy;
    logic [SUMX_W-1:0]    sum_x;
    logic [SUMY_W-1:0]    sum_y;

    // Arbitration scratch
    logic                 found;
    logic [IDX_W:0]       cand_sum;
    logic [IDX_W-1:0]     cand;

    // Per-requester views of the packed field buses
    logic [7:0]           x_arr   [NUM_REQ];
    logic [6:0]           y_arr   [NUM_REQ];
    logic [SIZE_W-1:0]    w_arr   [NUM_REQ];
    logic [SIZE_W-1:0]    h_arr   [NUM_REQ];
    logic [2:0]           col_arr [NUM_REQ];

    for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_unpack
        assign x_arr[g]   = rect_x[8*g +: 8];
        assign y_arr[g]   = rect_y[7*g +: 7];
        assign w_arr[g]   = rect_w[SIZE_W*g +: SIZE_W];
        assign h_arr[g]   = rect_h[SIZE_W*g +: SIZE_W];
        assign col_arr[g] = rect_colour[3*g +: 3];
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            ptr    <= '0;
            sel    <= '0;
            x0     <= '0;
            y0     <= '0;
            w      <= '0;
            h      <= '0;
            col    <= '0;
            cx     <= '0;
            cy     <= '0;
            grant  <= '0;
            done   <= '0;
            busy   <= 1'b0;
            x      <= '0;
            y      <= '0;
            colour <= '0;
            plot   <= 1'b0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            sel    <= sel_nxt;
            x0     <= x0_nxt;
            y0     <= y0_nxt;
            w      <= w_nxt;
            h      <= h_nxt;
            col    <= col_nxt;
            cx     <= cx_nxt;
            cy     <= cy_nxt;
            grant  <= grant_nxt;
            done   <= done_nxt;
            busy   <= busy_nxt;
            x      <= x_nxt;
            y      <= y_nxt;
            colour <= colour_nxt;
            plot   <= plot_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        sel_nxt    = sel;
        x0_nxt     = x0;
        y0_nxt     = y0;
        w_nxt      = w;
        h_nxt      = h;
        col_nxt    = col;
        cx_nxt     = cx;
        cy_nxt     = cy;
        grant_nxt  = grant;
        done_nxt   = '0;
        x_nxt      = x;
        y_nxt      = y;
        colour_nxt = colour;
        plot_nxt   = 1'b0;

        emit       = 1'b0;
        pix_x0     = x0;
        pix_y0     = y0;
        pix_col    = col;
        pix_cx     = cx;
        pix_cy     = cy;
        sum_x      = '0;
        sum_y      = '0;

        found      = 1'b0;
        cand_sum   = '0;
        cand       = '0;

        case (state)
            S_IDLE: begin
                // First pending requester at or after the pointer, wrapping
                for (int i = 0; i < int'(NUM_REQ); i++) begin
                    cand_sum = {1'b0, ptr} + (IDX_W+1)'(i);
                    if (cand_sum >= NUM_REQ_C) begin
                        cand_sum = cand_sum - NUM_REQ_C;
                    end
                    cand = cand_sum[IDX_W-1:0];
                    if (!found && req[cand]) begin
                        found   = 1'b1;
                        sel_nxt = cand;
                    end
                end
                if (found) begin
                    grant_nxt = NUM_REQ'(1) << sel_nxt;
                    state_nxt = S_LOAD;
                end
            end

            S_LOAD: begin
                x0_nxt  = x_arr[sel];
                y0_nxt  = y_arr[sel];
                w_nxt   = w_arr[sel];
                h_nxt   = h_arr[sel];
                col_nxt = col_arr[sel];
                cx_nxt  = '0;
                cy_nxt  = '0;
                if (w_arr[sel] == '0 || h_arr[sel] == '0) begin
                    state_nxt = S_DONE;
                    done_nxt  = grant;
                end else begin
                    // Present pixel (0,0) straight from the request fields
                    state_nxt = S_DRAW;
                    emit      = 1'b1;
                    pix_x0    = x_arr[sel];
                    pix_y0    = y_arr[sel];
                    pix_col   = col_arr[sel];
                    pix_cx    = '0;
                    pix_cy    = '0;
                end
            end

            S_DRAW: begin
                // cx/cy index the pixel currently on the port
                if (cx == w - SIZE_W'(1) && cy == h - SIZE_W'(1)) begin
                    state_nxt = S_DONE;
                    done_nxt  = grant;
                end else begin
                    if (cx == w - SIZE_W'(1)) begin
                        cx_nxt = '0;
                        cy_nxt = cy + SIZE_W'(1);
                    end else begin
                        cx_nxt = cx + SIZE_W'(1);
                    end
                    emit   = 1'b1;
                    pix_cx = cx_nxt;
                    pix_cy = cy_nxt;
                end
            end

            S_DONE: begin
                ptr_nxt   = (sel == LAST_IDX) ? '0 : sel + IDX_W'(1);
                grant_nxt = '0;
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Sums are widened so off-screen pixels clip instead of wrapping
        if (emit) begin
            sum_x      = SUMX_W'(pix_x0) + SUMX_W'(pix_cx);
            sum_y      = SUMY_W'(pix_y0) + SUMY_W'(pix_cy);
            x_nxt      = sum_x[7:0];
            y_nxt      = sum_y[6:0];
            colour_nxt = pix_col;
            plot_nxt   = (sum_x < SCREEN_W_C) && (sum_y < SCREEN_H_C);
        end

        busy_nxt = (state_nxt != S_IDLE);
    end

endmodule
